// File: rtl/nmr_acq_pkg.sv
// Shared definitions for the NMR echo capture block: stream word layout and
// the one-hot capture state encoding.
package nmr_acq_pkg;

    // Stream word layout: [31] FIRST, [30] LAST, [29:16] ECHO_IDX, [15:0] SAMPLE
    localparam int FIRST_BIT  = 31;
    localparam int LAST_BIT   = 30;
    localparam int IDX_MSB    = 29;
    localparam int IDX_LSB    = 16;
    localparam int SAMPLE_MSB = 15;

    typedef enum logic [4:0] {
        IDLE       = 5'b00001,
        ARMED      = 5'b00010,
        CAPTURE    = 5'b00100,
        WAIT_CLOSE = 5'b01000,
        FLUSH      = 5'b10000
    } state_e;

endpackage

// File: rtl/nmr_acq_fifo.sv
// First-word-fall-through FIFO, 32 bits wide, 2^AW deep. A write into a full
// FIFO is accepted only when a read happens in the same cycle.
module nmr_acq_fifo #(
    parameter int AW = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    input  logic        rd_en,
    output logic [31:0] rd_data,
    output logic        full,
    output logic        empty
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_wr, do_rd;

    assign full    = (cnt_q == FULL_CNT);
    assign empty   = (cnt_q == '0);
    // Head word is shown directly; the bus reads zero while nothing is stored.
    assign rd_data = empty ? 32'd0 : mem_q[rd_ptr_q];

    // Pointer and occupancy update.
    always_comb begin
        do_rd    = rd_en && !empty;
        do_wr    = wr_en && (!full || do_rd);
        wr_ptr_d = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({do_wr, do_rd})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Storage array, no reset needed: occupancy decides what is valid.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/nmr_acq_echo_capture.sv
// Echo capture: samples ADC data on ADC_CLK rising edges inside acquisition
// windows, tags words with echo index and FIRST/LAST, and streams them out
// through a FWFT FIFO. Each sample is held in a pending register so its LAST
// flag can be decided by the event that follows it.
// Stream: a word transfers when OUT_VALID && OUT_READY; OUT_DATA is held
// while OUT_VALID=1 and OUT_READY=0.
module nmr_acq_echo_capture
    import nmr_acq_pkg::*;
#(
    parameter int ADC_WIDTH = 14,
    parameter int FIFO_AW   = 9
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 FSMSTAT,
    input  logic                 ACQ_WND,
    input  logic                 ADC_CLK,
    input  logic [ADC_WIDTH-1:0] ADC_DATA,
    input  logic [15:0]          SAMPLES_PER_ECHO,
    output logic [31:0]          OUT_DATA,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic [15:0]          ECHO_CNT,
    output logic                 BUSY,
    output logic                 OVERFLOW,
    output logic                 SHORT_ECHO,
    output logic                 SCAN_DONE
);

    state_e      state_q, state_d;
    logic        adc_clk_q, fsmstat_q;
    logic [15:0] spe_q, spe_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] echo_cnt_q, echo_cnt_d;
    logic        busy_q, busy_d;
    logic        ovf_q, ovf_d;
    logic        short_q, short_d;
    logic        done_q, done_d;
    logic [31:0] pend_q, pend_d;
    logic        pend_vld_q, pend_vld_d;

    logic        sample_ev, fsm_rise, pop, push, fifo_wr, fifo_full, fifo_empty;
    logic [15:0] sample16, echo_inc;
    logic [31:0] new_word, last_word, push_word;

    assign OUT_VALID  = !fifo_empty;
    assign ECHO_CNT   = echo_cnt_q;
    assign BUSY       = busy_q;
    assign OVERFLOW   = ovf_q;
    assign SHORT_ECHO = short_q;
    assign SCAN_DONE  = done_q;

    // Event detection and word formatting.
    always_comb begin
        sample_ev = ADC_CLK && !adc_clk_q;
        fsm_rise  = FSMSTAT && !fsmstat_q;
        pop       = OUT_VALID && OUT_READY;
        echo_inc  = (echo_cnt_q == 16'hFFFF) ? echo_cnt_q : echo_cnt_q + 16'd1;
        sample16  = '0;
        sample16[ADC_WIDTH-1:0] = ADC_DATA;
        new_word  = '0;
        new_word[FIRST_BIT]          = (cnt_q == 16'd0);
        new_word[IDX_MSB:IDX_LSB]    = echo_cnt_q[13:0];
        new_word[SAMPLE_MSB:0]       = sample16;
        last_word = pend_q;
        last_word[LAST_BIT] = 1'b1;
    end

    // Capture state machine: next state, counters, pending word and FIFO push.
    always_comb begin
        state_d    = state_q;
        spe_d      = spe_q;
        cnt_d      = cnt_q;
        echo_cnt_d = echo_cnt_q;
        busy_d     = busy_q;
        ovf_d      = ovf_q;
        short_d    = short_q;
        done_d     = 1'b0;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        push       = 1'b0;
        push_word  = pend_q;
        case (state_q)
            IDLE: begin
                if (fsm_rise) begin
                    spe_d      = SAMPLES_PER_ECHO;
                    echo_cnt_d = '0;
                    ovf_d      = 1'b0;
                    short_d    = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = ARMED;
                end
            end
            ARMED: begin
                if (!FSMSTAT) begin
                    state_d = FLUSH;
                end else if (spe_q != 16'd0 && ACQ_WND) begin
                    cnt_d   = '0;
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                // A sample wins over a close in the same cycle; the close is
                // level-based, so it is still seen on the following cycle.
                if (sample_ev && cnt_q < spe_q) begin
                    push       = pend_vld_q;
                    pend_d     = new_word;
                    pend_vld_d = 1'b1;
                    cnt_d      = cnt_q + 16'd1;
                    if (cnt_q + 16'd1 == spe_q) begin
                        echo_cnt_d = echo_inc;
                        state_d    = WAIT_CLOSE;
                    end
                end else if (!ACQ_WND || !FSMSTAT) begin
                    if (pend_vld_q) begin
                        push       = 1'b1;
                        push_word  = last_word;
                        pend_vld_d = 1'b0;
                        short_d    = 1'b1;
                    end
                    if (cnt_q != 16'd0) echo_cnt_d = echo_inc;
                    state_d = FSMSTAT ? ARMED : FLUSH;
                end
            end
            WAIT_CLOSE: begin
                // The word that hit the limit leaves here, one cycle after load.
                if (pend_vld_q) begin
                    push       = 1'b1;
                    push_word  = last_word;
                    pend_vld_d = 1'b0;
                end
                if (!FSMSTAT)      state_d = FLUSH;
                else if (!ACQ_WND) state_d = ARMED;
            end
            FLUSH: begin
                if (pend_vld_q) begin
                    push      = 1'b1;
                    push_word = last_word;
                end
                pend_vld_d = 1'b0;
                done_d     = 1'b1;
                busy_d     = 1'b0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
        fifo_wr = push && (!fifo_full || pop);
        if (push && fifo_full && !pop) ovf_d = 1'b1;
    end

    // State and datapath registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= IDLE;
            adc_clk_q  <= 1'b0;
            fsmstat_q  <= 1'b0;
            spe_q      <= '0;
            cnt_q      <= '0;
            echo_cnt_q <= '0;
            busy_q     <= 1'b0;
            ovf_q      <= 1'b0;
            short_q    <= 1'b0;
            done_q     <= 1'b0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            adc_clk_q  <= ADC_CLK;
            fsmstat_q  <= FSMSTAT;
            spe_q      <= spe_d;
            cnt_q      <= cnt_d;
            echo_cnt_q <= echo_cnt_d;
            busy_q     <= busy_d;
            ovf_q      <= ovf_d;
            short_q    <= short_d;
            done_q     <= done_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
        end
    end

    nmr_acq_fifo #(.AW(FIFO_AW)) u_fifo (
        .clk     (CLK),
        .rst     (RESET),
        .wr_en   (fifo_wr),
        .wr_data (push_word),
        .rd_en   (pop),
        .rd_data (OUT_DATA),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_nmr_acq_echo_capture.sv
// Directed bench for nmr_acq_echo_capture with a 4-deep FIFO.
module tb_nmr_acq_echo_capture;

    localparam int ADC_W = 14;
    localparam int AW    = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             fsmstat, acq_wnd, adc_clk, out_ready;
    logic [ADC_W-1:0] adc_data;
    logic [15:0]      spe;
    logic [31:0]      out_data;
    logic             out_valid, busy, overflow, short_echo, scan_done;
    logic [15:0]      echo_cnt;

    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    int          done_cnt = 0;
    int          n_vec = 0;
    int          n_err = 0;

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    nmr_acq_echo_capture #(.ADC_WIDTH(ADC_W), .FIFO_AW(AW)) dut (
        .CLK              (clk),
        .RESET            (rst),
        .FSMSTAT          (fsmstat),
        .ACQ_WND          (acq_wnd),
        .ADC_CLK          (adc_clk),
        .ADC_DATA         (adc_data),
        .SAMPLES_PER_ECHO (spe),
        .OUT_DATA         (out_data),
        .OUT_VALID        (out_valid),
        .OUT_READY        (out_ready),
        .ECHO_CNT         (echo_cnt),
        .BUSY             (busy),
        .OVERFLOW         (overflow),
        .SHORT_ECHO       (short_echo),
        .SCAN_DONE        (scan_done)
    );

    // Stream and SCAN_DONE monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) got_q.push_back(out_data);
        if (!rst && scan_done) done_cnt++;
    end

    function automatic logic [31:0] mk(input logic f, input logic l,
                                       input logic [13:0] idx, input logic [13:0] s);
        return {f, l, idx, 2'b00, s};
    endfunction

    // Driver tasks: inputs change 1 time unit after the rising edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic adc_edges(input int n, input logic [13:0] base);
        for (int i = 0; i < n; i++) begin
            adc_clk  = 1'b1;
            adc_data = base + 14'(i);
            tick(2);
            adc_clk  = 1'b0;
            tick(2);
        end
    endtask

    task automatic start_scan(input logic [15:0] s);
        spe     = s;
        fsmstat = 1'b1;
        tick(2);
    endtask

    task automatic window(input int n, input logic [13:0] base);
        acq_wnd = 1'b1;
        tick(2);
        adc_edges(n, base);
        acq_wnd = 1'b0;
        tick(3);
    endtask

    task automatic end_scan();
        fsmstat = 1'b0;
        tick(4);
    endtask

    task automatic test_reset();
        rst = 1'b1; fsmstat = 1'b0; acq_wnd = 1'b0; adc_clk = 1'b0;
        adc_data = '0; spe = '0; out_ready = 1'b1;
        tick(3);
        n_vec++;
        if ({out_valid, out_data, echo_cnt, busy, overflow, short_echo, scan_done} !== 53'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got v=%b d=%h e=%h b=%b o=%b s=%b done=%b required all 0",
                     out_valid, out_data, echo_cnt, busy, overflow, short_echo, scan_done);
        end
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_capture_limit();
        exp_q.delete(); got_q.delete(); done_cnt = 0;
        start_scan(16'd4);
        n_vec++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL limit_busy: got %b required 1", busy); end
        window(5, 14'h0100);
        for (int i = 0; i < 4; i++) exp_q.push_back(mk(i == 0, i == 3, 14'd0, 14'h0100 + 14'(i)));
        n_vec++;
        if (got_q.size() !== exp_q.size()) begin
            n_err++; $display("FAIL limit_count: got %0d words required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL limit_word%0d: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
        n_vec++;
        if (echo_cnt !== 16'd1) begin n_err++; $display("FAIL limit_echo_cnt: got %0d required 1", echo_cnt); end
        n_vec++;
        if (short_echo !== 1'b0) begin n_err++; $display("FAIL limit_short: got %b required 0", short_echo); end
        end_scan();
        n_vec++;
        if (done_cnt !== 1) begin n_err++; $display("FAIL limit_done: got %0d pulses required 1", done_cnt); end
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL limit_busy_end: got %b required 0", busy); end
    endtask

    task automatic test_short_echo();
        exp_q.delete(); got_q.delete();
        start_scan(16'd8);
        window(3, 14'h3FFD);
        for (int i = 0; i < 3; i++) exp_q.push_back(mk(i == 0, i == 2, 14'd0, 14'h3FFD + 14'(i)));
        n_vec++;
        if (got_q.size() !== exp_q.size()) begin
            n_err++; $display("FAIL short_count: got %0d words required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL short_word%0d: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
        n_vec++;
        if (short_echo !== 1'b1) begin n_err++; $display("FAIL short_flag: got %b required 1", short_echo); end
        n_vec++;
        if (echo_cnt !== 16'd1) begin n_err++; $display("FAIL short_echo_cnt: got %0d required 1", echo_cnt); end
        end_scan();
    endtask

    task automatic test_back_to_back();
        exp_q.delete(); got_q.delete(); done_cnt = 0;
        start_scan(16'd2);
        for (int w = 0; w < 3; w++) begin
            window(3, 14'h0010 * 14'(w + 1));
            exp_q.push_back(mk(1'b1, 1'b0, 14'(w), 14'h0010 * 14'(w + 1)));
            exp_q.push_back(mk(1'b0, 1'b1, 14'(w), 14'h0010 * 14'(w + 1) + 14'd1));
        end
        n_vec++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy: got %b required 1", busy); end
        end_scan();
        n_vec++;
        if (got_q.size() !== exp_q.size()) begin
            n_err++; $display("FAIL b2b_count: got %0d words required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL b2b_word%0d: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
        n_vec++;
        if (echo_cnt !== 16'd3) begin n_err++; $display("FAIL b2b_echo_cnt: got %0d required 3", echo_cnt); end
        n_vec++;
        if (done_cnt !== 1) begin n_err++; $display("FAIL b2b_done: got %0d pulses required 1", done_cnt); end
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_busy_end: got %b required 0", busy); end
        n_vec++;
        if (short_echo !== 1'b0) begin n_err++; $display("FAIL b2b_short: got %b required 0", short_echo); end
    endtask

    task automatic test_overflow();
        exp_q.delete(); got_q.delete();
        out_ready = 1'b0;
        start_scan(16'd10);
        window(10, 14'h0A00);
        for (int i = 0; i < 4; i++) exp_q.push_back(mk(i == 0, 1'b0, 14'd0, 14'h0A00 + 14'(i)));
        n_vec++;
        if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b required 1", overflow); end
        n_vec++;
        if (out_valid !== 1'b1) begin n_err++; $display("FAIL ovf_valid: got %b required 1", out_valid); end
        n_vec++;
        if (out_data !== exp_q[0]) begin n_err++; $display("FAIL ovf_head: got %h required %h", out_data, exp_q[0]); end
        tick(5);
        n_vec++;
        if (out_data !== exp_q[0]) begin n_err++; $display("FAIL ovf_hold: got %h required %h", out_data, exp_q[0]); end
        out_ready = 1'b1;
        tick(8);
        n_vec++;
        if (got_q.size() !== exp_q.size()) begin
            n_err++; $display("FAIL ovf_count: got %0d words required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL ovf_word%0d: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL ovf_drained: got %b required 0", out_valid); end
        end_scan();
        n_vec++;
        if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b required 1", overflow); end
    endtask

    task automatic test_disabled();
        got_q.delete(); done_cnt = 0;
        start_scan(16'd0);
        n_vec++;
        if (overflow !== 1'b0) begin n_err++; $display("FAIL dis_ovf_clear: got %b required 0", overflow); end
        window(4, 14'h0555);
        window(2, 14'h0666);
        end_scan();
        n_vec++;
        if (got_q.size() !== 0) begin n_err++; $display("FAIL dis_count: got %0d words required 0", got_q.size()); end
        n_vec++;
        if (echo_cnt !== 16'd0) begin n_err++; $display("FAIL dis_echo_cnt: got %0d required 0", echo_cnt); end
        n_vec++;
        if (done_cnt !== 1) begin n_err++; $display("FAIL dis_done: got %0d pulses required 1", done_cnt); end
    endtask

    task automatic test_reset_mid_capture();
        exp_q.delete(); got_q.delete();
        out_ready = 1'b0;
        start_scan(16'd4);
        acq_wnd = 1'b1;
        tick(2);
        adc_edges(2, 14'h0200);
        n_vec++;
        if (out_valid !== 1'b1) begin n_err++; $display("FAIL rst_pre_valid: got %b required 1", out_valid); end
        rst = 1'b1; fsmstat = 1'b0; acq_wnd = 1'b0;
        tick(1);
        n_vec++;
        if ({out_valid, out_data, echo_cnt, busy, overflow, short_echo, scan_done} !== 53'd0) begin
            n_err++;
            $display("FAIL rst_mid_outputs: got v=%b d=%h e=%h b=%b o=%b s=%b done=%b required all 0",
                     out_valid, out_data, echo_cnt, busy, overflow, short_echo, scan_done);
        end
        rst = 1'b0; out_ready = 1'b1; done_cnt = 0; got_q.delete();
        tick(4);
        n_vec++;
        if (done_cnt !== 0) begin n_err++; $display("FAIL rst_no_done: got %0d pulses required 0", done_cnt); end
        start_scan(16'd2);
        window(2, 14'h0300);
        end_scan();
        exp_q.push_back(mk(1'b1, 1'b0, 14'd0, 14'h0300));
        exp_q.push_back(mk(1'b0, 1'b1, 14'd0, 14'h0301));
        n_vec++;
        if (got_q.size() !== exp_q.size()) begin
            n_err++; $display("FAIL rst_restart_count: got %0d words required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL rst_restart_word%0d: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
        n_vec++;
        if (done_cnt !== 1) begin n_err++; $display("FAIL rst_restart_done: got %0d pulses required 1", done_cnt); end
    endtask

    // Test sequence and final report.
    initial begin
        test_reset();
        test_capture_limit();
        test_short_echo();
        test_back_to_back();
        test_overflow();
        test_disabled();
        test_reset_mid_capture();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
